// File: rtl/pixel_replacement_pipe_if.sv
// pixel_replacement_pipe_if: input-beat and output-beat valid/ready stream bundle for the pixel replacement pipe
interface pixel_replacement_pipe_if #(
  parameter int PIX_W = 32,
  parameter int K_W   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] pixel_in;
  logic [PIX_W-1:0] weighted_mean;
  logic [PIX_W-1:0] std_dev;
  logic [K_W-1:0]   k_mult;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] pixel_out;
  logic             bad_flag;
  modport slave (
    input  in_valid, pixel_in, weighted_mean, std_dev, k_mult, mode, out_ready,
    output in_ready, out_valid, pixel_out, bad_flag
  );
  modport master (
    output in_valid, pixel_in, weighted_mean, std_dev, k_mult, mode, out_ready,
    input  in_ready, out_valid, pixel_out, bad_flag
  );
endinterface

// File: rtl/pixel_replacement_pipe.sv
// pixel_replacement_pipe: 2-stage valid/ready pipe flagging pixels beyond k*std_dev of the mean and replacing them per mode
module pixel_replacement_pipe #(
  parameter int PIX_W = 32,
  parameter int K_W   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_replacement_pipe_if.slave px,
  input  logic                 cnt_clr_i,
  output logic [CNT_W-1:0]     replaced_cnt_o
);
  localparam int TW = PIX_W + K_W;
  logic             s1_valid_q;
  logic [PIX_W-1:0] s1_diff_q, s1_pix_q, s1_mean_q;
  logic [TW-1:0]    s1_thr_q;
  logic [1:0]       s1_mode_q;
  logic             s2_valid_q, s2_bad_q;
  logic [PIX_W-1:0] s2_pix_q, last_good_q;
  logic [1:0]       s2_mode_q;
  logic             lg_seen_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s1_adv, in_xfer, s2_load, bad_d, cnt_inc;
  logic [PIX_W-1:0] diff_d, clamp_d, repl_d, pix_d;
  logic [TW-1:0]    thr_d, mean_ext;
  always_comb begin
    s1_adv         = !s2_valid_q || px.out_ready;
    px.in_ready    = !s1_valid_q || s1_adv;
    px.out_valid   = s2_valid_q;
    px.pixel_out   = s2_pix_q;
    px.bad_flag    = s2_bad_q;
    replaced_cnt_o = cnt_q;
    in_xfer        = px.in_valid && px.in_ready;
    s2_load        = s1_valid_q && s1_adv;
    diff_d         = px.pixel_in > px.weighted_mean ? px.pixel_in - px.weighted_mean
                                                    : px.weighted_mean - px.pixel_in;
    thr_d          = TW'(px.k_mult) * TW'(px.std_dev);
    mean_ext       = TW'(s1_mean_q);
    bad_d          = TW'(s1_diff_q) > s1_thr_q;
    // the clamp bound lies between pixel and mean, so truncation back to PIX_W is lossless
    clamp_d        = s1_pix_q > s1_mean_q ? PIX_W'(mean_ext + s1_thr_q) : PIX_W'(mean_ext - s1_thr_q);
    repl_d         = s1_mode_q == 2'd1 ? s1_mean_q
                   : s1_mode_q == 2'd2 ? (lg_seen_q ? last_good_q : s1_mean_q)
                   : clamp_d;
    pix_d          = bad_d && s1_mode_q != 2'd0 ? repl_d : s1_pix_q;
    cnt_inc        = s2_valid_q && px.out_ready && s2_bad_q && s2_mode_q != 2'd0 && cnt_q != '1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      s1_thr_q    <= '0;
      s1_pix_q    <= '0;
      s1_mean_q   <= '0;
      s1_mode_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_pix_q    <= '0;
      s2_bad_q    <= 1'b0;
      s2_mode_q   <= '0;
      last_good_q <= '0;
      lg_seen_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (px.in_ready) s1_valid_q <= px.in_valid;
      if (in_xfer) begin
        s1_diff_q <= diff_d;
        s1_thr_q  <= thr_d;
        s1_pix_q  <= px.pixel_in;
        s1_mean_q <= px.weighted_mean;
        s1_mode_q <= px.mode;
      end
      if (s1_adv) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        s2_pix_q  <= pix_d;
        s2_bad_q  <= bad_d;
        s2_mode_q <= s1_mode_q;
        if (!bad_d) begin
          last_good_q <= s1_pix_q;
          lg_seen_q   <= 1'b1;
        end
      end
      cnt_q <= cnt_clr_i ? '0 : cnt_q + CNT_W'(cnt_inc);
    end
  end
endmodule

// File: tb/tb_pixel_replacement_pipe.sv
// tb_pixel_replacement_pipe: directed vectors, queue-based reference model and per-cycle output compare
module tb_pixel_replacement_pipe;
  localparam int PIX_W = 8;
  localparam int K_W   = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
  typedef struct { int pix; int bad; int mode; } exp_t;
  typedef struct { int pix; int bad; } got_t;
  logic clk, reset, cnt_clr;
  logic [CNT_W-1:0] replaced_cnt;
  pixel_replacement_pipe_if #(.PIX_W(PIX_W), .K_W(K_W)) ifc ();
  pixel_replacement_pipe #(.PIX_W(PIX_W), .K_W(K_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .px(ifc.slave), .cnt_clr_i(cnt_clr), .replaced_cnt_o(replaced_cnt)
  );
  int n_chk = 0, n_pass = 0;
  exp_t exp_q[$];
  got_t got[$];
  int m_cnt = 0, lg = 0, lg_seen = 0, acc_cnt = 0;
  bit fdone;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  // reference model: classification and replacement evaluated in acceptance order
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      exp_q.delete();
      m_cnt = 0; lg = 0; lg_seen = 0;
    end else begin
      int xfer_bad;
      xfer_bad = 0;
      if (ifc.out_valid && ifc.out_ready) begin
        got.push_back('{int'(ifc.pixel_out), int'(ifc.bad_flag)});
        if (exp_q.size() > 0) begin
          xfer_bad = exp_q[0].bad && exp_q[0].mode != 0;
          void'(exp_q.pop_front());
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if (xfer_bad && m_cnt < CMAX) m_cnt++;
      if (ifc.in_valid && ifc.in_ready) begin
        int p, m, thr, d, b, o, md;
        p = int'(ifc.pixel_in); m = int'(ifc.weighted_mean); md = int'(ifc.mode);
        thr = int'(ifc.k_mult) * int'(ifc.std_dev);
        d = p > m ? p - m : m - p;
        b = d > thr;
        if (!b || md == 0) o = p;
        else if (md == 1) o = m;
        else if (md == 2) o = lg_seen ? lg : m;
        else o = p > m ? m + thr : m - thr;
        if (!b) begin lg = p; lg_seen = 1; end
        exp_q.push_back('{o, b, md});
        acc_cnt++;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("replaced_cnt", int'(replaced_cnt), m_cnt);
      if (ifc.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          chk("pixel_out", int'(ifc.pixel_out), exp_q[0].pix);
          chk("bad_flag", int'(ifc.bad_flag), exp_q[0].bad);
        end
      end
    end
  end
  task automatic send(int p, int md, int m = 100, int s = 10, int k = 2);
    bit ok;
    @(negedge clk);
    ifc.pixel_in = PIX_W'(p); ifc.weighted_mean = PIX_W'(m);
    ifc.std_dev = PIX_W'(s); ifc.k_mult = K_W'(k); ifc.mode = 2'(md);
    ifc.in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      ok = ifc.in_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask
  task automatic idle();
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask
  task automatic drain(int n);
    for (int i = 0; i < 200 && got.size() < n; i++) @(negedge clk);
    chk("drain_count", got.size(), n);
  endtask
  task automatic lit(string nm, int i, int p, int b);
    chk({nm, "_pix"}, i < got.size() ? got[i].pix : -1, p);
    chk({nm, "_bad"}, i < got.size() ? got[i].bad : -1, b);
  endtask
  task automatic wait_fdone();
    for (int i = 0; i < 200 && !fdone; i++) @(negedge clk);
    chk("feeder_done", int'(fdone), 1);
  endtask
  initial begin
    reset = 0; cnt_clr = 0;
    ifc.in_valid = 0; ifc.out_ready = 1; ifc.pixel_in = 0; ifc.weighted_mean = 0;
    ifc.std_dev = 0; ifc.k_mult = 0; ifc.mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(ifc.out_valid), 0);
    chk("rst_pixel_out", int'(ifc.pixel_out), 0);
    chk("rst_bad_flag", int'(ifc.bad_flag), 0);
    chk("rst_cnt", int'(replaced_cnt), 0);
    chk("rst_in_ready", int'(ifc.in_ready), 1);
    @(negedge clk) reset = 1;
    // mode 1 with latency probe
    send(125, 1);
    @(negedge clk) ifc.in_valid = 0;
    chk("lat_cycle1_valid", int'(ifc.out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2_valid", int'(ifc.out_valid), 1);
    chk("lat_cycle2_pix", int'(ifc.pixel_out), 100);
    send(120, 1); idle();
    drain(2);
    lit("m1_125", 0, 100, 1);
    lit("m1_120", 1, 120, 0);
    got.delete();
    // mode 3 clamp, plus a threshold wider than PIX_W
    send(125, 3); send(60, 3); send(100, 3); send(140, 3, 100, 10, 3); send(0, 3, 255, 20, 15); idle();
    drain(5);
    lit("m3_125", 0, 120, 1);
    lit("m3_60", 1, 80, 1);
    lit("m3_100", 2, 100, 0);
    lit("m3_140k3", 3, 130, 1);
    lit("m3_widethr", 4, 0, 0);
    // mode 2 from a fresh reset
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
    got.delete();
    send(200, 2); send(110, 2); send(250, 2); send(5, 2); idle();
    drain(4);
    lit("m2_200", 0, 100, 1);
    lit("m2_110", 1, 110, 0);
    lit("m2_250", 2, 110, 1);
    lit("m2_5", 3, 110, 1);
    // mode 0 bypass does not count
    @(negedge clk) cnt_clr = 1;
    @(negedge clk) cnt_clr = 0;
    chk("clr_cnt", int'(replaced_cnt), 0);
    got.delete();
    send(250, 0); idle();
    drain(1);
    lit("m0_250", 0, 250, 1);
    chk("m0_cnt", int'(replaced_cnt), 0);
    // saturation
    got.delete();
    repeat (4) send(130, 1);
    idle();
    drain(4);
    lit("sat_last", 3, 100, 1);
    chk("sat_cnt", int'(replaced_cnt), 3);
    // clear coincident with a counted output
    got.delete();
    send(130, 1); idle();
    for (int i = 0; i < 20 && !ifc.out_valid; i++) @(negedge clk);
    cnt_clr = 1;
    @(negedge clk) cnt_clr = 0;
    chk("clr_prio_cnt", int'(replaced_cnt), 0);
    send(130, 1); idle();
    drain(2);
    chk("post_clr_cnt", int'(replaced_cnt), 1);
    // back-pressure
    got.delete();
    @(negedge clk) ifc.out_ready = 0;
    begin
      int acc0;
      acc0 = acc_cnt;
      fdone = 0;
      fork
        begin
          send(101, 1); send(102, 1); send(130, 1); send(103, 1); send(104, 1); send(105, 1);
          idle();
          fdone = 1;
        end
      join_none
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        if (i >= 2) begin
          chk("bp_in_ready", int'(ifc.in_ready), 0);
          chk("bp_out_valid", int'(ifc.out_valid), 1);
          chk("bp_hold_pix", int'(ifc.pixel_out), 101);
        end
      end
      chk("bp_accepted", acc_cnt - acc0, 2);
    end
    ifc.out_ready = 1;
    wait_fdone();
    drain(6);
    lit("bp0", 0, 101, 0);
    lit("bp1", 1, 102, 0);
    lit("bp2", 2, 100, 1);
    lit("bp3", 3, 103, 0);
    lit("bp4", 4, 104, 0);
    lit("bp5", 5, 105, 0);
    // asynchronous reset mid-stream
    fdone = 0;
    fork
      begin
        repeat (4) send(130, 1);
        idle();
        fdone = 1;
      end
    join_none
    for (int i = 0; i < 20 && !(ifc.out_valid && replaced_cnt != 0); i++) @(negedge clk);
    chk("pre_rst_valid", int'(ifc.out_valid), 1);
    #2 reset = 0;
    #1;
    chk("arst_out_valid", int'(ifc.out_valid), 0);
    chk("arst_cnt", int'(replaced_cnt), 0);
    chk("arst_pix", int'(ifc.pixel_out), 0);
    chk("arst_bad", int'(ifc.bad_flag), 0);
    wait_fdone();
    @(negedge clk) reset = 1;
    repeat (3) @(negedge clk);
    chk("arst_discard_valid", int'(ifc.out_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pixel_replacement_pipe.md
Name: pixel_replacement_pipe

Overview:
- Parametrised, streaming successor to the single-mode pixel replacement block.
- Each incoming pixel is tested against a per-pixel weighted mean and standard deviation. A pixel is bad when |pixel - mean| > k_mult*std_dev.
- A bad pixel is replaced according to a selectable mode.
- Sits between the statistics generator (mean/std_dev source) and the downstream image path. Adds valid/ready back-pressure, a 2-stage pipeline and a replaced-pixel counter.

Parameters:
- PIX_W, 32, width of pixel, mean and std_dev.
- K_W, 4, width of the unsigned integer threshold multiplier k_mult.
- CNT_W, 16, width of the replaced-pixel counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel_in, weighted_mean, std_dev, k_mult and mode are valid.
- in_ready  out  1  block accepts the input beat this cycle.
- pixel_in  in  PIX_W  unsigned input pixel.
- weighted_mean  in  PIX_W  unsigned local mean for this pixel.
- std_dev  in  PIX_W  unsigned local standard deviation for this pixel.
- k_mult  in  K_W  threshold multiplier.
- mode  in  2  0 = bypass, 1 = replace with mean, 2 = replace with last good pixel, 3 = clamp to mean±threshold.
- out_valid  out  1  pixel_out and bad_flag are valid.
- out_ready  in  1  downstream accepts the output beat.
- pixel_out  out  PIX_W  corrected pixel.
- bad_flag  out  1  pixel was classified bad; set regardless of mode, including bypass.
- cnt_clr  in  1  synchronous clear of replaced_cnt.
- replaced_cnt  out  CNT_W  number of output beats with bad_flag=1 and mode≠0, saturating.

Behaviour:
- Reset (reset=0, asynchronous): both stage valid bits, pixel_out, bad_flag, replaced_cnt and the last-good register clear to 0. The last-good-seen flag clears to 0. Releasing reset is synchronous to clk. A beat in flight when reset asserts is discarded, not emitted.
- Handshake: a transfer occurs when valid && ready on the same edge.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready.
  - out_valid = s2_valid. The pipeline stalls fully while out_ready=0.
  - Data on pixel_out and bad_flag is held stable while out_valid=1 && out_ready=0.
- Stage 1 (captures on input transfer):
  - Registers diff = |pixel_in - weighted_mean| (PIX_W bits).
  - Registers thr = k_mult*std_dev (PIX_W+K_W bits, no truncation).
  - Registers pixel, mean, mode.
- Stage 2 (captures on s1_advance when s1_valid):
  - bad = ({K_W'b0,diff} > thr); strictly greater, so equality is good.
  - mode 0: pixel_out = pixel.
  - mode 1: pixel_out = bad ? mean : pixel.
  - mode 2: pixel_out = bad ? (last_good_seen ? last_good : mean) : pixel.
  - mode 3: pixel_out = bad ? (pixel > mean ? mean+thr : mean-thr) : pixel. The result always fits PIX_W because the bound lies between pixel and mean.
- Last-good register: on stage-2 capture of a good pixel (any mode), last_good ← pixel and last_good_seen ← 1. A bad pixel leaves both unchanged.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 beat/cycle with out_ready held at 1.
- Counter: increments by 1 on each output transfer with bad_flag=1 && mode≠0. It saturates at 2^CNT_W-1. cnt_clr has priority over an increment in the same cycle: the result is 0.
- mode and k_mult are sampled per beat with the pixel. Changing them mid-stream affects only beats accepted afterwards.

Test Plan:
- PIX_W=8, mean=100, std_dev=10, k_mult=2, mode=1: pixel 125 → out 100, bad_flag=1; pixel 120 → out 120, bad_flag=0 (equality is good); output 2 cycles after input.
- Same stats, mode=3: pixel 125 → 120; pixel 60 → 80; pixel 100 → 100, bad_flag=0.
- mode=2 after reset: stream 200 → 100 (no good pixel seen yet, falls back to mean); then 110 → 110, 250 → 110, 5 → 110.
- mode=0: pixel 250 → out 250, bad_flag=1, replaced_cnt unchanged.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - in_ready drops after 2 beats are accepted.
  - pixel_out stays stable throughout.
  - On release, all beats emerge in order with no loss or duplication.
- CNT_W=2: 4 bad beats → replaced_cnt = 3 (saturated); cnt_clr coincident with a bad output → 0.
- Async reset asserted mid-stream with out_valid=1 → out_valid=0, replaced_cnt=0 immediately, without waiting for a clock edge.
